// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU/DMA memory arbiter.
// Holds the FSM state encoding, the owner encoding and the parameter defaults.
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 1;
    // Counter width covers the legal MEM_LAT range of 1..7.
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU port, DMA port, shared memory port and busy.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ready,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ready,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
// MEM_ARB_RR_EN: alternate on contention using last_owner; otherwise CPU wins.
module mem_arb_pick import mem_arb_pkg::*; (
    input  logic   cpu_req,
    input  logic   dma_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   grant,
    output owner_t winner
);

    always_comb begin
        grant = cpu_req | dma_req;
`ifdef MEM_ARB_RR_EN
        if (cpu_req && dma_req)
            winner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        else
            winner = cpu_req ? OWN_CPU : OWN_DMA;
`else
        winner = cpu_req ? OWN_CPU : OWN_DMA;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, DMA) arbiter in front of a single-port memory with MEM_LAT read latency.
// Optional MEM_ARB_RR_EN: round-robin on contention instead of fixed CPU priority.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    state_t            state;
    state_t            next_state;
    owner_t            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              grant;
    owner_t            winner;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_owner <= OWN_DMA;
        else if (state == ST_IDLE && grant)
            last_owner <= winner;
    end
`endif

    mem_arb_pick u_pick (
        .cpu_req    (bus.cpu_req),
        .dma_req    (bus.dma_req),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .grant      (grant),
        .winner     (winner)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= winner;
                        we_q    <= (winner == OWN_CPU) ? bus.cpu_we    : bus.dma_we;
                        addr_q  <= (winner == OWN_CPU) ? bus.cpu_addr  : bus.dma_addr;
                        wdata_q <= (winner == OWN_CPU) ? bus.cpu_wdata : bus.dma_wdata;
                        cnt     <= CNT_W'(MEM_LAT);
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt - 1'b1;
                    // Read data lands straight in the owner's port register; stores leave it alone.
                    if (cnt == CNT_W'(1) && !we_q) begin
                        if (owner_q == OWN_CPU)
                            cpu_rdata_q <= bus.mem_rdata;
                        else
                            dma_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state    = state;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.dma_ready = 1'b0;
        bus.busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (grant)
                    next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                // The counter still holds MEM_LAT only in the first ACCESS cycle.
                bus.mem_we    = we_q && (cnt == CNT_W'(MEM_LAT));
                if (cnt == CNT_W'(1))
                    next_state = ST_RESP;
            end
            ST_RESP: begin
                bus.cpu_ready = (owner_q == OWN_CPU);
                bus.dma_ready = (owner_q == OWN_DMA);
                next_state    = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Expectations adapt to MEM_ARB_RR_EN for the contention sequence.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic [31:0] mem_rdata;
        logic        exp_cpu;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_cpu_rdata;
        logic [31:0] exp_dma_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_cpu;

        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
        bus1.dma_req = 0; bus1.dma_we = 0; bus1.dma_addr = 0; bus1.dma_wdata = 0;
        bus1.mem_rdata = 0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
        bus3.dma_req = 0; bus3.dma_we = 0; bus3.dma_addr = 0; bus3.dma_wdata = 0;
        bus3.mem_rdata = 0;

        vecs[0] = '{1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 32'hDEADBEEF,
                    1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1, 1, 32'h104, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 32'h11111111,
                    1, 1, 32'h104, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{0, 0, 32'h0, 32'h0, 1, 0, 32'h200, 32'h0BAD0001, 32'hCAFEF00D,
                    0, 0, 32'h200, 32'h0BAD0001, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1, 0, 32'hFFFFFFFC, 32'h33333333, 0, 0, 32'h0, 32'h0, 32'h0,
                    1, 0, 32'hFFFFFFFC, 32'h33333333, 32'h0, 32'hCAFEF00D};
        vecs[4] = '{0, 0, 32'h0, 32'h0, 1, 1, 32'h208, 32'h5A5A0000, 32'h22222222,
                    0, 1, 32'h208, 32'h5A5A0000, 32'h0, 32'hCAFEF00D};

        // Reset state of both instances.
        step();
        step();
        check("rst busy1",      bus1.busy,      0);
        check("rst mem_addr1",  bus1.mem_addr,  0);
        check("rst mem_we1",    bus1.mem_we,    0);
        check("rst mem_wdata1", bus1.mem_wdata, 0);
        check("rst cpu_ready1", bus1.cpu_ready, 0);
        check("rst dma_ready1", bus1.dma_ready, 0);
        check("rst cpu_rdata1", bus1.cpu_rdata, 0);
        check("rst dma_rdata1", bus1.dma_rdata, 0);
        check("rst busy3",      bus3.busy,      0);
        rst = 1'b1;
        step();

        // Single transactions at MEM_LAT=1: IDLE, ACCESS, RESP, back to IDLE.
        for (int i = 0; i < 5; i++) begin
            bus1.cpu_req   = vecs[i].cpu_req;
            bus1.cpu_we    = vecs[i].cpu_we;
            bus1.cpu_addr  = vecs[i].cpu_addr;
            bus1.cpu_wdata = vecs[i].cpu_wdata;
            bus1.dma_req   = vecs[i].dma_req;
            bus1.dma_we    = vecs[i].dma_we;
            bus1.dma_addr  = vecs[i].dma_addr;
            bus1.dma_wdata = vecs[i].dma_wdata;
            bus1.mem_rdata = vecs[i].mem_rdata;
            step();
            check($sformatf("v%0d access busy", i),  bus1.busy,      1);
            check($sformatf("v%0d mem_addr", i),     bus1.mem_addr,  vecs[i].exp_addr);
            check($sformatf("v%0d mem_wdata", i),    bus1.mem_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d mem_we", i),       bus1.mem_we,    vecs[i].exp_we);
            check($sformatf("v%0d early ready", i),  bus1.cpu_ready | bus1.dma_ready, 0);
            step();
            bus1.cpu_req = 0;
            bus1.dma_req = 0;
            check($sformatf("v%0d cpu_ready", i),    bus1.cpu_ready, vecs[i].exp_cpu);
            check($sformatf("v%0d dma_ready", i),    bus1.dma_ready, !vecs[i].exp_cpu);
            check($sformatf("v%0d cpu_rdata", i),    bus1.cpu_rdata, vecs[i].exp_cpu_rdata);
            check($sformatf("v%0d dma_rdata", i),    bus1.dma_rdata, vecs[i].exp_dma_rdata);
            check($sformatf("v%0d resp mem_we", i),  bus1.mem_we,    0);
            step();
            check($sformatf("v%0d idle busy", i),    bus1.busy,      0);
            check($sformatf("v%0d idle mem_addr", i), bus1.mem_addr, 0);
            check($sformatf("v%0d idle ready", i),   bus1.cpu_ready | bus1.dma_ready, 0);
        end

        // DMA store at MEM_LAT=3: write strobe only in the first ACCESS cycle.
        bus3.dma_req = 1; bus3.dma_we = 1; bus3.dma_addr = 32'h40; bus3.dma_wdata = 32'h12345678;
        step();
        check("st3 c1 mem_we",    bus3.mem_we,    1);
        check("st3 c1 mem_addr",  bus3.mem_addr,  32'h40);
        check("st3 c1 mem_wdata", bus3.mem_wdata, 32'h12345678);
        step();
        check("st3 c2 mem_we",    bus3.mem_we,    0);
        check("st3 c2 mem_addr",  bus3.mem_addr,  32'h40);
        check("st3 c2 dma_ready", bus3.dma_ready, 0);
        step();
        check("st3 c3 mem_we",    bus3.mem_we,    0);
        check("st3 c3 mem_addr",  bus3.mem_addr,  32'h40);
        check("st3 c3 dma_ready", bus3.dma_ready, 0);
        step();
        bus3.dma_req = 0; bus3.dma_we = 0;
        check("st3 c4 dma_ready", bus3.dma_ready, 1);
        check("st3 c4 cpu_ready", bus3.cpu_ready, 0);
        check("st3 c4 dma_rdata", bus3.dma_rdata, 0);
        step();
        check("st3 c5 dma_ready", bus3.dma_ready, 0);
        check("st3 c5 busy",      bus3.busy,      0);

        // CPU load at MEM_LAT=3: data captured in the last ACCESS cycle only.
        bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 32'h80; bus3.mem_rdata = 32'hAAAA0000;
        step();
        bus3.mem_rdata = 32'hAAAA0001;
        step();
        bus3.mem_rdata = 32'hAAAA0002;
        step();
        bus3.mem_rdata = 32'hAAAA0003;
        check("ld3 c3 cpu_ready", bus3.cpu_ready, 0);
        step();
        bus3.cpu_req = 0;
        bus3.mem_rdata = 32'hFFFF0000;
        check("ld3 c4 cpu_ready", bus3.cpu_ready, 1);
        check("ld3 c4 cpu_rdata", bus3.cpu_rdata, 32'hAAAA0003);
        step();
        check("ld3 c5 cpu_ready", bus3.cpu_ready, 0);
        check("ld3 c5 cpu_rdata hold", bus3.cpu_rdata, 32'hAAAA0003);
        check("ld3 c5 busy",      bus3.busy,      0);

        // Both requesters held high: fixed priority or alternation.
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 32'h300;
        bus1.dma_req = 1; bus1.dma_we = 0; bus1.dma_addr = 32'h400;
        bus1.mem_rdata = 32'h31415926;
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
            exp_cpu = (g % 2 == 0);
`else
            exp_cpu = 1'b1;
`endif
            step();
            check($sformatf("cont g%0d mem_addr", g), bus1.mem_addr, exp_cpu ? 32'h300 : 32'h400);
            step();
            check($sformatf("cont g%0d cpu_ready", g), bus1.cpu_ready, exp_cpu);
            check($sformatf("cont g%0d dma_ready", g), bus1.dma_ready, !exp_cpu);
            if (g == 3) begin
                bus1.cpu_req = 0;
                bus1.dma_req = 0;
            end
            step();
            check($sformatf("cont g%0d idle", g), bus1.busy, 0);
        end

        // Reset during ACCESS of a CPU load abandons it without a ready pulse.
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 32'h500; bus1.mem_rdata = 32'h77777777;
        step();
        check("rstmid pre busy",     bus1.busy,     1);
        check("rstmid pre mem_addr", bus1.mem_addr, 32'h500);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid busy",      bus1.busy,      0);
        check("rstmid mem_we",    bus1.mem_we,    0);
        check("rstmid mem_addr",  bus1.mem_addr,  0);
        check("rstmid cpu_ready", bus1.cpu_ready, 0);
        check("rstmid cpu_rdata", bus1.cpu_rdata, 0);
        bus1.cpu_req = 0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rstmid after%0d ready", k), bus1.cpu_ready, 0);
            check($sformatf("rstmid after%0d busy", k),  bus1.busy,      0);
        end
        bus1.cpu_req = 1; bus1.cpu_addr = 32'h600; bus1.mem_rdata = 32'h600D600D;
        step();
        check("rstmid next mem_addr", bus1.mem_addr, 32'h600);
        step();
        bus1.cpu_req = 0;
        check("rstmid next cpu_ready", bus1.cpu_ready, 1);
        check("rstmid next cpu_rdata", bus1.cpu_rdata, 32'h600D600D);
        step();
        check("rstmid next idle", bus1.busy, 0);

        // CPU drops req mid-access; pending DMA is served right after.
        bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 32'h700;
        bus3.dma_req = 1; bus3.dma_we = 0; bus3.dma_addr = 32'h800;
        bus3.mem_rdata = 32'h0BADCAFE;
        step();
        check("drop c1 mem_addr", bus3.mem_addr, 32'h700);
        bus3.cpu_req = 0;
        step();
        step();
        step();
        check("drop c4 cpu_ready", bus3.cpu_ready, 1);
        check("drop c4 dma_ready", bus3.dma_ready, 0);
        check("drop c4 cpu_rdata", bus3.cpu_rdata, 32'h0BADCAFE);
        bus3.mem_rdata = 32'h13572468;
        step();
        check("drop c5 busy", bus3.busy, 0);
        step();
        check("drop c6 busy",     bus3.busy,     1);
        check("drop c6 mem_addr", bus3.mem_addr, 32'h800);
        step();
        step();
        step();
        bus3.dma_req = 0;
        check("drop c9 dma_ready", bus3.dma_ready, 1);
        check("drop c9 cpu_ready", bus3.cpu_ready, 0);
        check("drop c9 dma_rdata", bus3.dma_rdata, 32'h13572468);
        check("drop c9 cpu_rdata", bus3.cpu_rdata, 32'h0BADCAFE);
        step();
        check("drop c10 busy", bus3.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
